branch_execute: RTL
===================

BRANCH_EXECUTE -- requirements
Module: branch_execute

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the decoded-branch input handshake; transfer occurs when both are high at a clk edge.
REQ-004 SHALL have decoded-field inputs: is_nop (1), is_jmp (1), is_imm_type (1), zero_ext (1), op (2), rd (5) and imm (22), carrying the branch decode stage's field meanings.
REQ-005 SHALL have operand inputs: pc (input, 32, instruction address), rs1_val (input, 32) and rs2_val (input, 32), the register read values.
REQ-006 SHALL have link-writeback outputs: out_valid (output, 1), out_ready (input, 1), wb_en (output, 1), wb_rd (output, 5) and wb_data (output, 32).
REQ-007 SHALL have redirect outputs: redirect_valid (output, 1), redirect_pc (output, 32), redirect_ack (input, 1) and flush (output, 1, a one-cycle upstream squash pulse).
REQ-008 SHALL have output taken_cnt, 16 bits: a saturating count of redirects issued.

Function
REQ-009 SHALL classify each instruction: is_jmp=0 is a conditional branch; is_jmp=1 with is_imm_type=0 is JAL; is_jmp=1 with is_imm_type=1 is JALR.
REQ-010 SHALL compute the conditional-branch target as pc + sext({imm[11:0],1'b0}), 32-bit with wrap-around.
REQ-011 SHALL compute the JAL target as pc + sext({imm[19:0],1'b0}), wrap-around.
REQ-012 SHALL compute the JALR target as (rs1_val + sext(imm[11:0])) with bit0 cleared.
REQ-013 SHALL evaluate the condition from op: 00 = EQ, 01 = NE, 10 = LT, 11 = GE, comparing rs1_val against rs2_val.
REQ-014 SHALL treat LT/GE as unsigned when zero_ext=1 and signed otherwise; zero_ext SHALL be ignored for EQ/NE.
REQ-015 SHALL treat JAL and JALR as always taken.
REQ-016 SHALL consume an accepted instruction with is_nop=1 with no output, no redirect and no counter change.
REQ-017 SHALL, for an accepted non-NOP instruction, register a result with 1-cycle latency: out_valid high from the following cycle.
REQ-018 SHALL drive the registered result as wb_en = is_jmp && rd!=0, wb_rd = rd, wb_data = pc+4, for both branches and jumps.
REQ-019 SHALL hold out_valid and all wb_* outputs stable while out_valid=1 and out_ready=0.
REQ-020 SHALL implement FSM state RUN, in which in_ready = !out_valid || out_ready.
REQ-021 SHALL implement FSM state REDIR, in which in_ready = 0.
REQ-022 SHALL, on accepting a taken instruction in RUN, register redirect_pc, set redirect_valid, increment taken_cnt and enter REDIR.
REQ-023 SHALL hold redirect_valid and redirect_pc stable in REDIR until redirect_ack=1 is sampled.
REQ-024 SHALL, on that ack, clear redirect_valid, pulse flush high for exactly one cycle and return to RUN; in_ready may rise no earlier than the cycle after the ack.
REQ-025 SHALL ignore redirect_ack when redirect_valid=0.
REQ-026 SHALL keep the out_* handshake and the redirect handshake independent, so both may complete on the same edge.
REQ-027 SHALL saturate taken_cnt at 16'hFFFF.

Reset
REQ-028 SHALL, while rst_n=0, force the FSM to RUN and hold at 0 in_ready, out_valid, wb_en, wb_rd, wb_data, redirect_valid, redirect_pc, flush and taken_cnt.
REQ-029 SHALL release in_ready from the first edge after reset deassertion.
REQ-030 SHALL, on reset asserted mid-REDIR or with out_valid pending, discard the pending redirect and result without emitting flush.

Structure
REQ-031 SHALL place in a shared package branch_pkg: the XLEN=32 and IMM_W=22 constants, the op enum (BR_EQ, BR_NE, BR_LT, BR_GE) and the FSM state enum (RUN, REDIR).
REQ-032 SHALL implement the condition evaluation as one combinational sub-module, branch_compare (inputs a, b, op, zero_ext; output taken).

Verification
REQ-033 SHALL verify a signed BLT: op=10, zero_ext=0, rs1=FFFFFFFF, rs2=1, pc=100, imm[11:0]=008 -> redirect_pc=110, wb_en=0, taken_cnt=1.
REQ-034 SHALL verify an unsigned BLTU: op=10, zero_ext=1, rs1=FFFFFFFF, rs2=1 -> not taken, out_valid for 1 cycle, no redirect, in_ready stays high.
REQ-035 SHALL verify JALR: rs1=1003, imm=FFF, rd=1, pc=200 -> redirect_pc=1002, wb_rd=1, wb_data=204; hold redirect_ack=0 for 3 cycles -> redirect_valid held, in_ready=0; ack -> flush pulses once.
REQ-036 SHALL verify back-pressure: out_ready=0 for 4 cycles after a JAL with rd=5 -> wb_* stable, in_ready=0 in RUN; out_ready=1 with redirect_ack on the same edge -> both complete.
REQ-037 SHALL verify NOP and x0: is_nop=1 -> no out_valid; JAL with rd=0 -> wb_en=0, redirect issued.
REQ-038 SHALL verify reset and saturation: reset asserted in REDIR -> all outputs 0, no flush; preload taken_cnt=FFFF plus a taken branch -> remains FFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and enums for the branch execute unit.
package branch_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 22;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_op_e;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_compare.sv
// Conditional-branch comparator: decides whether rs1 vs rs2 satisfies op.
module branch_compare
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  br_op_e          op,
  input  logic            zero_ext,
  output logic            taken
);

  // Equality ignores zero_ext; ordering picks unsigned or signed by zero_ext.
  always_comb begin
    taken = 1'b0;
    case (op)
      BR_EQ:   taken = (a == b);
      BR_NE:   taken = (a != b);
      BR_LT:   taken = zero_ext ? (a < b) : ($signed(a) < $signed(b));
      BR_GE:   taken = zero_ext ? (a >= b) : ($signed(a) >= $signed(b));
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_execute.sv
// Branch execute stage: resolves branches/jumps, emits link writeback and
// holds a redirect request until the fetch side acknowledges it.
module branch_execute
  import branch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_nop,
  input  logic             is_jmp,
  input  logic             is_imm_type,
  input  logic             zero_ext,
  input  logic [1:0]       op,
  input  logic [4:0]       rd,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_e        state_q, state_d;
  logic             ready_en_q;
  logic             out_valid_q, out_valid_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             cond_taken;
  logic             taken;
  logic             issue;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jal_target;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;
  logic             unused_imm;

  branch_compare u_compare (
    .a        (rs1_val),
    .b        (rs2_val),
    .op       (br_op_e'(op)),
    .zero_ext (zero_ext),
    .taken    (cond_taken)
  );

  // ready_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready   = ready_en_q && (state_q == RUN) && (!out_valid_q || out_ready);
  assign issue      = in_valid && in_ready && !is_nop;
  assign unused_imm = ^imm[IMM_W-1:20];

  // Target address and taken decision for the instruction on the inputs.
  always_comb begin
    br_target  = pc + {{(XLEN-13){imm[11]}}, imm[11:0], 1'b0};
    jal_target = pc + {{(XLEN-21){imm[19]}}, imm[19:0], 1'b0};
    jalr_sum   = rs1_val + {{(XLEN-12){imm[11]}}, imm[11:0]};
    target     = br_target;
    taken      = cond_taken;
    if (is_jmp) begin
      taken  = 1'b1;
      target = is_imm_type ? {jalr_sum[XLEN-1:1], 1'b0} : jal_target;
    end
  end

  // Next-state for the result register, redirect FSM and taken counter.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    wb_en_d       = wb_en_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = 1'b0;
    taken_cnt_d   = taken_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (issue) begin
      out_valid_d = 1'b1;
      wb_en_d     = is_jmp && (rd != 5'd0);
      wb_rd_d     = rd;
      wb_data_d   = pc + 32'd4;
    end

    case (state_q)
      RUN: begin
        if (issue && taken) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = target;
          state_d       = REDIR;
          if (taken_cnt_q != {CNT_W{1'b1}}) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
          end
        end
      end
      REDIR: begin
        if (redirect_ack) begin
          redir_valid_d = 1'b0;
          flush_d       = 1'b1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; reset drops any pending result or redirect silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      ready_en_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ready_en_q    <= 1'b1;
      out_valid_q   <= out_valid_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign flush          = flush_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
